// File: rtl/pipe_pkg.sv
// Shared types for the EX->MEM pipeline register: payload layout, occupancy states
// and default widths for the RV32I datapath.
package pipe_pkg;

    localparam int DATA_WIDTH_DEF       = 32;
    localparam int REG_ADDR_WIDTH_DEF   = 5;
    localparam int RESULT_SRC_WIDTH_DEF = 2;

    typedef struct packed {
        logic                            reg_write;
        logic [RESULT_SRC_WIDTH_DEF-1:0] result_src;
        logic                            mem_write;
        logic [2:0]                      funct3;
        logic [DATA_WIDTH_DEF-1:0]       alu_result;
        logic [DATA_WIDTH_DEF-1:0]       write_data;
        logic [REG_ADDR_WIDTH_DEF-1:0]   rd;
        logic [DATA_WIDTH_DEF-1:0]       pc_plus4;
    } ex_mem_payload_t;

    // Encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_ONE   = 2'b10,
        OCC_FULL  = 2'b11
    } occ_state_t;

    function automatic logic occ_main_valid(input occ_state_t s);
        return s[1];
    endfunction

    function automatic logic occ_skid_valid(input occ_state_t s);
        return s[0];
    endfunction

endpackage

// File: rtl/skid_buf.sv
// Generic one-entry skid buffer: main register feeds the output, skid register absorbs
// the one beat accepted while the consumer stalls. Upstream ready is registered.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   OCC_EMPTY | nothing held, upstream ready
//   OCC_ONE   | main holds the output beat, upstream ready
//   OCC_FULL  | main and skid both hold beats, upstream stalled
module skid_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic             i_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output occ_state_t       o_state
);

    occ_state_t       r_state;
    occ_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_accept;
    logic             w_retire;
    logic             w_load_main;
    logic             w_load_skid;
    logic             w_skid_to_main;
    logic             w_clear;

    assign w_accept = i_valid && (r_state != OCC_FULL);
    assign w_retire = (r_state != OCC_EMPTY) && i_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        w_clear        = 1'b0;
        if (i_flush) begin
            // A same-cycle retire has already been sampled downstream; only held beats die.
            w_state_nxt = OCC_EMPTY;
            w_clear     = 1'b1;
        end else begin
            case (r_state)
                OCC_EMPTY: begin
                    if (w_accept) begin
                        w_load_main = 1'b1;
                        w_state_nxt = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (w_accept && w_retire) begin
                        w_load_main = 1'b1;
                    end else if (w_retire) begin
                        w_state_nxt = OCC_EMPTY;
                    end else if (w_accept) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = OCC_FULL;
                    end
                end
                OCC_FULL: begin
                    if (w_retire) begin
                        w_skid_to_main = 1'b1;
                        w_state_nxt    = OCC_ONE;
                    end
                end
                default: begin
                    w_state_nxt = OCC_EMPTY;
                    w_clear     = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= OCC_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) begin
                r_main <= i_data;
            end else if (w_skid_to_main) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= i_data;
            end
        end
    end

    assign o_data  = r_main;
    assign o_state = r_state;

    a_no_illegal_occ : assert property (@(posedge clk) disable iff (rst)
        r_state inside {OCC_EMPTY, OCC_ONE, OCC_FULL});

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with valid/ready handshake, skid buffering and flush.
// Define EX_MEM_PERF_CNT_EN to add the stall_cnt/flush_cnt performance counters.
module ex_mem_stage
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
    parameter int REG_ADDR_WIDTH   = REG_ADDR_WIDTH_DEF,
    parameter int RESULT_SRC_WIDTH = RESULT_SRC_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        validE,
    output logic                        readyE,
    input  logic                        RegWriteE,
    input  logic [RESULT_SRC_WIDTH-1:0] ResultSrcE,
    input  logic                        MemWriteE,
    input  logic [2:0]                  Funct3E,
    input  logic [DATA_WIDTH-1:0]       ALUResultE,
    input  logic [DATA_WIDTH-1:0]       WriteDataE,
    input  logic [REG_ADDR_WIDTH-1:0]   RdE,
    input  logic [DATA_WIDTH-1:0]       PCPlus4E,
    output logic                        validM,
    input  logic                        readyM,
    output logic                        RegWriteM,
    output logic [RESULT_SRC_WIDTH-1:0] ResultSrcM,
    output logic                        MemWriteM,
    output logic [2:0]                  Funct3M,
    output logic [DATA_WIDTH-1:0]       ALUResultM,
    output logic [DATA_WIDTH-1:0]       WriteDataM,
    output logic [REG_ADDR_WIDTH-1:0]   RdM,
    output logic [DATA_WIDTH-1:0]       PCPlus4M
`ifdef EX_MEM_PERF_CNT_EN
    ,
    output logic [31:0]                 stall_cnt,
    output logic [31:0]                 flush_cnt
`endif
);

    // Width-parametrised counterpart of pipe_pkg::ex_mem_payload_t.
    typedef struct packed {
        logic                        reg_write;
        logic [RESULT_SRC_WIDTH-1:0] result_src;
        logic                        mem_write;
        logic [2:0]                  funct3;
        logic [DATA_WIDTH-1:0]       alu_result;
        logic [DATA_WIDTH-1:0]       write_data;
        logic [REG_ADDR_WIDTH-1:0]   rd;
        logic [DATA_WIDTH-1:0]       pc_plus4;
    } payload_t;

    payload_t   w_pl_in;
    payload_t   w_pl_out;
    occ_state_t w_occ;
    logic       w_main_valid;
    logic       w_skid_valid;

    assign w_pl_in = '{
        reg_write:  RegWriteE,
        result_src: ResultSrcE,
        mem_write:  MemWriteE,
        funct3:     Funct3E,
        alu_result: ALUResultE,
        write_data: WriteDataE,
        rd:         RdE,
        pc_plus4:   PCPlus4E
    };

    skid_buf #(
        .WIDTH($bits(payload_t))
    ) u_skid_buf (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_valid (validE),
        .i_ready (readyM),
        .i_data  (w_pl_in),
        .o_data  (w_pl_out),
        .o_state (w_occ)
    );

    assign w_main_valid = occ_main_valid(w_occ);
    assign w_skid_valid = occ_skid_valid(w_occ);

    assign readyE     = ~w_skid_valid;
    assign validM     = w_main_valid;
    // Write enables are masked by registered occupancy so a bubble can never write.
    assign RegWriteM  = w_pl_out.reg_write & w_main_valid;
    assign MemWriteM  = w_pl_out.mem_write & w_main_valid;
    assign ResultSrcM = w_pl_out.result_src;
    assign Funct3M    = w_pl_out.funct3;
    assign ALUResultM = w_pl_out.alu_result;
    assign WriteDataM = w_pl_out.write_data;
    assign RdM        = w_pl_out.rd;
    assign PCPlus4M   = w_pl_out.pc_plus4;

`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic [1:0]  w_squash;

    // A main entry retiring alongside the flush was consumed, so it is not counted.
    assign w_squash = {1'b0, w_main_valid & ~readyM} + {1'b0, w_skid_valid};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_main_valid && !readyM) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (flush) begin
                r_flush_cnt <= r_flush_cnt + {30'd0, w_squash};
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed and short random stimulus for ex_mem_stage, checked against a queue of
// expected in-flight instructions.
module tb_ex_mem_stage;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        validE;
    logic        readyE;
    logic        RegWriteE;
    logic [1:0]  ResultSrcE;
    logic        MemWriteE;
    logic [2:0]  Funct3E;
    logic [31:0] ALUResultE;
    logic [31:0] WriteDataE;
    logic [4:0]  RdE;
    logic [31:0] PCPlus4E;
    logic        validM;
    logic        readyM;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [4:0]  RdM;
    logic [31:0] PCPlus4M;
`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    ex_mem_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .validE     (validE),
        .readyE     (readyE),
        .RegWriteE  (RegWriteE),
        .ResultSrcE (ResultSrcE),
        .MemWriteE  (MemWriteE),
        .Funct3E    (Funct3E),
        .ALUResultE (ALUResultE),
        .WriteDataE (WriteDataE),
        .RdE        (RdE),
        .PCPlus4E   (PCPlus4E),
        .validM     (validM),
        .readyM     (readyM),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .RdM        (RdM),
        .PCPlus4M   (PCPlus4M)
`ifdef EX_MEM_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    ex_mem_payload_t q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    bit          model_known = 1'b0;
    bit          seen9       = 1'b0;
    logic [31:0] exp_stall   = '0;
    logic [31:0] exp_flush   = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ex_mem_payload_t mk(input logic [31:0] alu, input logic [4:0] rd,
                                           input logic mw, input logic rw);
        ex_mem_payload_t p;
        p.reg_write  = rw;
        p.result_src = rd[1:0];
        p.mem_write  = mw;
        p.funct3     = rd[2:0];
        p.alu_result = alu;
        p.write_data = alu ^ 32'hA5A5_0000;
        p.rd         = rd;
        p.pc_plus4   = alu + 32'd4;
        return p;
    endfunction

    task automatic check_outputs();
        chk("readyE", 64'(readyE), 64'(q.size() < 2));
        chk("validM", 64'(validM), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("RegWriteM",  64'(RegWriteM),  64'(q[0].reg_write));
            chk("ResultSrcM", 64'(ResultSrcM), 64'(q[0].result_src));
            chk("MemWriteM",  64'(MemWriteM),  64'(q[0].mem_write));
            chk("Funct3M",    64'(Funct3M),    64'(q[0].funct3));
            chk("ALUResultM", 64'(ALUResultM), 64'(q[0].alu_result));
            chk("WriteDataM", 64'(WriteDataM), 64'(q[0].write_data));
            chk("RdM",        64'(RdM),        64'(q[0].rd));
            chk("PCPlus4M",   64'(PCPlus4M),   64'(q[0].pc_plus4));
        end else begin
            chk("RegWriteM_bubble", 64'(RegWriteM), 64'd0);
            chk("MemWriteM_bubble", 64'(MemWriteM), 64'd0);
        end
`ifdef EX_MEM_PERF_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        chk("flush_cnt", 64'(flush_cnt), 64'(exp_flush));
`endif
        if (validM === 1'b1 && RdM === 5'd9) seen9 = 1'b1;
    endtask

    task automatic chk_zero();
        chk("zero_ResultSrcM", 64'(ResultSrcM), 64'd0);
        chk("zero_Funct3M",    64'(Funct3M),    64'd0);
        chk("zero_ALUResultM", 64'(ALUResultM), 64'd0);
        chk("zero_WriteDataM", 64'(WriteDataM), 64'd0);
        chk("zero_RdM",        64'(RdM),        64'd0);
        chk("zero_PCPlus4M",   64'(PCPlus4M),   64'd0);
    endtask

    // One clock: drive inputs, check the registered outputs, advance the model.
    task automatic step(input logic v, input ex_mem_payload_t p, input logic rdy,
                        input logic fl, input logic rs);
        int  pre;
        bit  acc;
        bit  ret;
        @(negedge clk);
        validE     = v;
        RegWriteE  = p.reg_write;
        ResultSrcE = p.result_src;
        MemWriteE  = p.mem_write;
        Funct3E    = p.funct3;
        ALUResultE = p.alu_result;
        WriteDataE = p.write_data;
        RdE        = p.rd;
        PCPlus4E   = p.pc_plus4;
        readyM     = rdy;
        flush      = fl;
        rst        = rs;
        if (model_known) check_outputs();
        pre = q.size();
        if (rs) begin
            q.delete();
            exp_stall   = '0;
            exp_flush   = '0;
            model_known = 1'b1;
        end else begin
            acc = v && (pre < 2) && !fl;
            ret = (pre > 0) && rdy;
            if (pre > 0 && !rdy) exp_stall = exp_stall + 32'd1;
            if (ret) void'(q.pop_front());
            if (fl) begin
                exp_flush = exp_flush + 32'(pre - (ret ? 1 : 0));
                q.delete();
            end else if (acc) begin
                q.push_back(p);
            end
        end
    endtask

    ex_mem_payload_t idle;

    initial begin
        idle = mk(32'h0, 5'd0, 1'b0, 1'b0);
        rst = 1'b1; flush = 1'b0; validE = 1'b0; readyM = 1'b0;
        RegWriteE = 1'b0; ResultSrcE = '0; MemWriteE = 1'b0; Funct3E = '0;
        ALUResultE = '0; WriteDataE = '0; RdE = '0; PCPlus4E = '0;

        // Reset then free-flowing stream
        step(1'b0, idle, 1'b0, 1'b0, 1'b1);
        step(1'b0, idle, 1'b0, 1'b0, 1'b1);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);
        chk_zero();
        step(1'b1, mk(32'h10, 5'd1, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk(32'h20, 5'd2, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk(32'h30, 5'd3, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk(32'h40, 5'd4, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);

        // Back-pressure: 5 in main, 6 in skid, 7 held off until release
        step(1'b1, mk(32'h50, 5'd5, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(32'h60, 5'd6, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(32'h70, 5'd7, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(32'h70, 5'd7, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk(32'h70, 5'd7, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);

        // Flush while FULL with a store waiting in skid
        step(1'b1, mk(32'h100, 5'd10, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(32'h110, 5'd11, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0);
        step(1'b0, idle, 1'b0, 1'b1, 1'b0);
        step(1'b0, idle, 1'b0, 1'b0, 1'b0);

        // Flush in ONE with a same-cycle retire
        step(1'b1, mk(32'h120, 5'd12, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);

        // Flush with a simultaneous accept of rd 9
        step(1'b1, mk(32'h130, 5'd13, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(32'h900, 5'd9, 1'b1, 1'b1), 1'b0, 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);
        chk("rd9_never_seen", 64'(seen9), 64'd0);

        // Reset while FULL and stalled
        step(1'b1, mk(32'h140, 5'd14, 1'b1, 1'b1), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(32'h150, 5'd15, 1'b1, 1'b1), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(32'h160, 5'd16, 1'b1, 1'b1), 1'b0, 1'b0, 1'b1);
        step(1'b0, idle, 1'b0, 1'b0, 1'b0);
        chk_zero();
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);

        // Random traffic, back-pressure and occasional flush
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)),
                 mk($urandom, 5'($urandom_range(10, 31)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1))),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 15) == 0),
                 1'b0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, idle, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
